// File: rtl/uart_bus_controller.sv
// Bus-mapped 8N1 UART: DATA/STATUS registers with one TX and one RX FIFO.
// interrupt[0] tracks RX FIFO non-empty.
module uart_bus_controller #(
  parameter int CLK_FREQ   = 30_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] data_wr,
  input  logic [3:0]  mask,
  output logic        stall,
  output logic [31:0] data_rd,
  output logic [31:0] data_rd_2,
  output logic [5:0]  interrupt,
  output logic        txd,
  input  logic        rxd
);

  localparam int DIV = (CLK_FREQ + BAUD_RATE / 2) / BAUD_RATE;
  localparam int CW  = $clog2(DIV);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;

  logic [7:0]  tx_mem [FIFO_DEPTH];
  logic [7:0]  rx_mem [FIFO_DEPTH];
  logic [AW:0] tx_wp, tx_rp, rx_wp, rx_rp;
  logic        tx_full, tx_empty, rx_full, rx_empty;
  logic        tx_push, tx_pop, rx_push, rx_pop;
  logic [7:0]  tx_head;

  logic        is_data, rd_data, rd_status, wr_data_req;
  logic        unused_bits;

  uart_state_t tx_state, rx_state;
  logic [CW-1:0] tx_cnt, rx_cnt;
  logic [2:0]  tx_bit, rx_bit;
  logic [7:0]  tx_shreg, rx_shreg;
  logic        rxd_m, rxd_s, rxd_s_q;
  logic        rx_stop_sample;
  logic        overrun, frame_err;

  assign unused_bits = ^{address[31:3], address[1:0], data_wr[31:8], mask[3:1]};

  // A simultaneous read and write is a write: the read neither returns data nor pops.
  assign is_data     = ~address[2];
  assign wr_data_req = write & is_data & mask[0];
  assign rd_data     = read & ~write & is_data;
  assign rd_status   = read & ~write & address[2];

  assign tx_empty = (tx_wp == tx_rp);
  assign tx_full  = (tx_wp[AW] != tx_rp[AW]) && (tx_wp[AW-1:0] == tx_rp[AW-1:0]);
  assign rx_empty = (rx_wp == rx_rp);
  assign rx_full  = (rx_wp[AW] != rx_rp[AW]) && (rx_wp[AW-1:0] == rx_rp[AW-1:0]);

  assign stall   = wr_data_req & tx_full;
  assign tx_push = wr_data_req & ~tx_full;
  assign rx_pop  = rd_data & ~rx_empty;
  assign tx_head = tx_mem[tx_rp[AW-1:0]];

  // The TX FIFO is drained from IDLE or straight out of STOP, so frames run back to back.
  assign tx_pop = ~tx_empty &
                  ((tx_state == S_IDLE) || ((tx_state == S_STOP) && (tx_cnt == DIV_LAST)));

  assign rx_stop_sample = (rx_state == S_STOP) && (rx_cnt == DIV_LAST);
  assign rx_push        = rx_stop_sample & rxd_s & ~rx_full;

  assign data_rd_2 = '0;
  assign interrupt = {5'b0, ~rx_empty};

  always_comb begin
    data_rd = '0;
    if (rd_data && !rx_empty)
      data_rd = {24'b0, rx_mem[rx_rp[AW-1:0]]};
    else if (rd_status)
      data_rd = {28'b0, overrun, frame_err, ~rx_empty, ~tx_full};
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp[AW-1:0]] <= data_wr[7:0];
    if (rx_push) rx_mem[rx_wp[AW-1:0]] <= rx_shreg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wp <= '0;
      tx_rp <= '0;
      rx_wp <= '0;
      rx_rp <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop)  tx_rp <= tx_rp + 1'b1;
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop)  rx_rp <= rx_rp + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shreg <= '0;
      txd      <= 1'b1;
    end else begin
      case (tx_state)
        S_IDLE: begin
          if (tx_pop) begin
            tx_shreg <= tx_head;
            tx_cnt   <= '0;
            txd      <= 1'b0;
            tx_state <= S_START;
          end
        end
        S_START: begin
          if (tx_cnt == DIV_LAST) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            txd      <= tx_shreg[0];
            tx_shreg <= {1'b0, tx_shreg[7:1]};
            tx_state <= S_DATA;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (tx_cnt == DIV_LAST) begin
            tx_cnt <= '0;
            if (tx_bit == 3'd7) begin
              txd      <= 1'b1;
              tx_state <= S_STOP;
            end else begin
              tx_bit   <= tx_bit + 1'b1;
              txd      <= tx_shreg[0];
              tx_shreg <= {1'b0, tx_shreg[7:1]};
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: begin
          if (tx_cnt == DIV_LAST) begin
            tx_cnt <= '0;
            if (tx_pop) begin
              tx_shreg <= tx_head;
              txd      <= 1'b0;
              tx_state <= S_START;
            end else begin
              tx_state <= S_IDLE;
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_m     <= 1'b1;
      rxd_s     <= 1'b1;
      rxd_s_q   <= 1'b1;
      rx_state  <= S_IDLE;
      rx_cnt    <= '0;
      rx_bit    <= '0;
      rx_shreg  <= '0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rxd_m   <= rxd;
      rxd_s   <= rxd_m;
      rxd_s_q <= rxd_s;
      // A new error in the same cycle as a STATUS read stays set rather than being lost.
      overrun   <= (overrun & ~rd_status) | (rx_stop_sample & rxd_s & rx_full);
      frame_err <= (frame_err & ~rd_status) | (rx_stop_sample & ~rxd_s);
      case (rx_state)
        S_IDLE: begin
          if (rxd_s_q && !rxd_s) begin
            rx_cnt   <= '0;
            rx_state <= S_START;
          end
        end
        S_START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rxd_s ? S_IDLE : S_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (rx_cnt == DIV_LAST) begin
            rx_cnt   <= '0;
            rx_shreg <= {rxd_s, rx_shreg[7:1]};
            if (rx_bit == 3'd7) rx_state <= S_STOP;
            else                rx_bit   <= rx_bit + 1'b1;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: begin
          if (rx_cnt == DIV_LAST) begin
            rx_cnt   <= '0;
            rx_state <= S_IDLE;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_bus_controller.sv
// Scoreboard bench for uart_bus_controller: stimulus queues expected values,
// a negedge monitor pops and compares on every bus read or probe strobe.
module tb_uart_bus_controller;

  localparam int DIV = 260;
  localparam logic [31:0] A_DATA   = 32'h0300_0000;
  localparam logic [31:0] A_STATUS = 32'h0300_0004;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] address;
  logic        read, write;
  logic [31:0] data_wr;
  logic [3:0]  mask;
  logic        stall;
  logic [31:0] data_rd, data_rd_2;
  logic [5:0]  interrupt;
  logic        txd;
  logic        rxd_line, rxd_drv, loop_en;
  logic        probe_r;

  int checks = 0;
  int errors = 0;

  int          qk[$];
  logic [31:0] qe[$];
  string       qn[$];

  assign rxd_line = loop_en ? txd : rxd_drv;

  uart_bus_controller #(
    .CLK_FREQ  (30_000_000),
    .BAUD_RATE (115200),
    .FIFO_DEPTH(16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .address  (address),
    .read     (read),
    .write    (write),
    .data_wr  (data_wr),
    .mask     (mask),
    .stall    (stall),
    .data_rd  (data_rd),
    .data_rd_2(data_rd_2),
    .interrupt(interrupt),
    .txd      (txd),
    .rxd      (rxd_line)
  );

  always #5 clk = ~clk;

  initial begin
    #950000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // Monitor: kind 0/4 = data_rd, 1 = txd, 2 = stall, 3 = interrupt.
  always @(negedge clk) begin
    if (probe_r || (read && !write)) begin
      checks++;
      if (qk.size() == 0) begin
        errors++;
        $display("FAIL unexpected_sample: got data_rd=0x%0h required a queued expectation", data_rd);
      end else begin
        int          k;
        logic [31:0] e, act;
        string       n;
        k = qk.pop_front();
        e = qe.pop_front();
        n = qn.pop_front();
        case (k)
          1:       act = {31'b0, txd};
          2:       act = {31'b0, stall};
          3:       act = {26'b0, interrupt};
          default: act = data_rd;
        endcase
        if (act !== e) begin
          errors++;
          $display("FAIL %s: got 0x%0h required 0x%0h", n, act, e);
        end
      end
    end
  end

  task automatic push_exp(input int k, input logic [31:0] e, input string n);
    qk.push_back(k);
    qe.push_back(e);
    qn.push_back(n);
  endtask

  task automatic probe(input int k, input logic [31:0] e, input string n);
    #1;
    push_exp(k, e, n);
    probe_r = 1'b1;
    @(negedge clk);
    #1 probe_r = 1'b0;
  endtask

  task automatic timeout_fail(input string n);
    checks++;
    errors++;
    $display("FAIL %s: got timeout required event", n);
  endtask

  task automatic bus_read(input logic [31:0] addr, input logic [31:0] e, input string n);
    @(posedge clk);
    #1;
    address = addr;
    read    = 1'b1;
    push_exp(0, e, n);
    @(posedge clk);
    #1 read = 1'b0;
  endtask

  task automatic bus_write(input logic [7:0] d, output int stall_cycles);
    @(posedge clk);
    #1;
    address = A_DATA;
    data_wr = {24'hABCDEF, d};
    mask    = 4'b0001;
    write   = 1'b1;
    stall_cycles = 0;
    @(negedge clk);
    while (stall && stall_cycles < 4000) begin
      @(negedge clk);
      stall_cycles++;
    end
    if (stall_cycles >= 4000) timeout_fail("write_stall_bound");
    @(posedge clk);
    #1;
    write = 1'b0;
    mask  = 4'b0000;
  endtask

  task automatic wait_txd_fall(input string n);
    int cnt = 0;
    while (txd !== 1'b0 && cnt < 4000) begin
      @(negedge clk);
      cnt++;
    end
    if (cnt >= 4000) timeout_fail(n);
  endtask

  initial begin
    int          sc;
    int          cnt;
    logic [9:0]  pat;
    logic [9:0]  frm;
    logic [7:0]  eb;

    rst_n   = 1'b0;
    address = '0;
    read    = 1'b0;
    write   = 1'b0;
    data_wr = '0;
    mask    = '0;
    rxd_drv = 1'b1;
    loop_en = 1'b0;
    probe_r = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    probe(1, 32'h1, "reset_txd");
    probe(2, 32'h0, "reset_stall");
    probe(3, 32'h0, "reset_interrupt");
    probe(4, 32'h0, "reset_data_rd");
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus_read(A_STATUS, 32'h1, "reset_status");
    bus_read(A_DATA,   32'h0, "empty_data_read");

    // TX waveform of 0x55: start, LSB-first data, stop
    bus_write(8'h55, sc);
    wait_txd_fall("tx55_start");
    repeat (DIV / 2 - 1) @(negedge clk);
    pat = 10'b10_1010_1010;
    for (int i = 0; i < 10; i++) begin
      probe(1, {31'b0, pat[i]}, $sformatf("tx55_bit%0d", i));
      repeat (DIV - 1) @(negedge clk);
    end
    repeat (DIV) @(posedge clk);

    // Loopback of 0xA3
    loop_en = 1'b1;
    bus_write(8'hA3, sc);
    cnt = 0;
    while (interrupt[0] !== 1'b1 && cnt < 4000) begin
      @(negedge clk);
      cnt++;
    end
    if (cnt >= 4000) timeout_fail("loop_irq_wait");
    probe(3, 32'h1, "loop_interrupt");
    @(posedge clk);
    #1;
    address = A_DATA;
    mask    = 4'b0000;
    read    = 1'b1;
    write   = 1'b1;
    push_exp(4, 32'h0, "rw_both_data_rd");
    probe_r = 1'b1;
    @(posedge clk);
    #1;
    read    = 1'b0;
    write   = 1'b0;
    probe_r = 1'b0;
    bus_read(A_DATA,   32'hA3, "loop_data");
    bus_read(A_STATUS, 32'h1,  "loop_status");
    probe(3, 32'h0, "loop_interrupt_cleared");
    repeat (2 * DIV) @(posedge clk);

    // Frame error: 0x3C with stop bit 0
    loop_en = 1'b0;
    frm = {1'b0, 8'h3C, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd_drv = frm[i];
      repeat (DIV) @(posedge clk);
    end
    rxd_drv = 1'b1;
    repeat (DIV) @(posedge clk);
    bus_read(A_STATUS, 32'h5, "frame_err_status");
    bus_read(A_STATUS, 32'h1, "frame_err_cleared");
    bus_read(A_DATA,   32'h0, "frame_err_no_push");

    // Start-bit glitch shorter than half a bit is ignored
    rxd_drv = 1'b0;
    repeat (40) @(posedge clk);
    rxd_drv = 1'b1;
    repeat (2 * DIV) @(posedge clk);
    bus_read(A_STATUS, 32'h1, "glitch_status");

    // TX FIFO full while busy, then RX overrun via loopback
    loop_en = 1'b1;
    bus_write(8'h10, sc);
    repeat (10) @(posedge clk);
    for (int i = 0; i < 16; i++) bus_write(8'h20 + 8'(i), sc);
    bus_read(A_STATUS, 32'h0, "tx_full_status");
    @(posedge clk);
    #1;
    address = A_DATA;
    data_wr = 32'h0000_0030;
    mask    = 4'b0001;
    write   = 1'b1;
    probe(2, 32'h1, "stall_when_full");
    cnt = 0;
    while (stall && cnt < 4000) begin
      @(negedge clk);
      cnt++;
    end
    @(posedge clk);
    #1;
    write = 1'b0;
    mask  = 4'b0000;
    checks++;
    if (cnt <= 9 * DIV || cnt >= 10 * DIV) begin
      errors++;
      $display("FAIL stall_duration: got %0d cycles required between %0d and %0d", cnt, 9 * DIV, 10 * DIV);
    end
    repeat (17 * 10 * DIV + 2 * DIV) @(posedge clk);
    bus_read(A_STATUS, 32'hB, "overrun_status");
    probe(3, 32'h1, "overrun_interrupt");
    for (int i = 0; i < 16; i++) begin
      eb = (i == 0) ? 8'h10 : 8'h20 + 8'(i - 1);
      bus_read(A_DATA, {24'b0, eb}, $sformatf("rx_fifo_entry%0d", i));
    end
    bus_read(A_DATA,   32'h0, "rx_drained_data");
    bus_read(A_STATUS, 32'h1, "rx_drained_status");
    repeat (DIV) @(posedge clk);

    // Reset during TX data bit 3 of 0x81
    loop_en = 1'b0;
    bus_write(8'h81, sc);
    wait_txd_fall("rst_mid_start");
    repeat (DIV / 2 - 1) @(negedge clk);
    repeat (4 * DIV) @(negedge clk);
    probe(1, 32'h0, "pre_reset_bit3");
    @(posedge clk);
    #2 rst_n = 1'b0;
    probe(1, 32'h1, "mid_reset_txd");
    probe(2, 32'h0, "mid_reset_stall");
    probe(3, 32'h0, "mid_reset_interrupt");
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus_read(A_STATUS, 32'h1, "post_reset_status");
    repeat (2 * DIV) @(posedge clk);
    probe(1, 32'h1, "post_reset_txd_idle");

    repeat (5) @(posedge clk);
    checks++;
    if (qk.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", qk.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
